// File: rtl/vco_adc_sequencer_if.sv
// Host and ADC-side signal bundle for the VCO ADC run sequencer.
// The slave modport is the sequencer; the master modport is the host/ADC side driving it.
interface vco_adc_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  start_in;
    logic                  stop_in;
    logic [CNT_WIDTH-1:0]  num_samples_in;
    logic [9:0]            oversample_cfg_in;
    logic                  adc_enable_out;
    logic [9:0]            adc_oversample_out;
    logic [DATA_WIDTH-1:0] adc_data_in;
    logic                  adc_valid_in;
    logic                  rd_en_in;
    logic [DATA_WIDTH-1:0] rd_data_out;
    logic                  rd_empty_out;
    logic                  busy_out;
    logic                  done_out;
    logic                  overflow_out;
    logic                  timeout_out;
    logic [CNT_WIDTH-1:0]  sample_cnt_out;

    modport slave (
        input  start_in, stop_in, num_samples_in, oversample_cfg_in,
        input  adc_data_in, adc_valid_in, rd_en_in,
        output adc_enable_out, adc_oversample_out, rd_data_out, rd_empty_out,
        output busy_out, done_out, overflow_out, timeout_out, sample_cnt_out
    );

    modport master (
        output start_in, stop_in, num_samples_in, oversample_cfg_in,
        output adc_data_in, adc_valid_in, rd_en_in,
        input  adc_enable_out, adc_oversample_out, rd_data_out, rd_empty_out,
        input  busy_out, done_out, overflow_out, timeout_out, sample_cnt_out
    );
endinterface

// File: rtl/vco_adc_sequencer.sv
// Run controller for one VCO ADC: latches a run request, gates the ADC enable with a
// guaranteed off-gap, counts and buffers conversion words in a FWFT FIFO, and reports
// done/overflow/timeout status to the host.
module vco_adc_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned OFF_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8192
) (
    input  logic               clk,
    input  logic               rst,
    vco_adc_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(OFF_CYCLES);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(OFF_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StGap,
        StRun
    } state_t;

    state_t                r_state, w_state_d;
    logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt_d;
    logic [TO_W-1:0]       r_to_cnt, w_to_cnt_d, w_to_inc;
    logic [CNT_WIDTH-1:0]  r_num, w_num_d;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_d, w_cnt_inc;
    logic [9:0]            r_os, w_os_d;
    logic                  r_en, r_busy;
    logic                  r_done, w_done_d;
    logic                  r_ovf, w_ovf_d;
    logic                  r_to, w_to_d;
    logic                  w_push_req;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [OCC_W-1:0]      r_occ, w_occ_d;
    logic                  w_full, w_empty, w_push, w_pop;

    assign w_full    = (r_occ == OCC_FULL);
    assign w_empty   = (r_occ == '0);
    assign w_pop     = bus.rd_en_in & ~w_empty;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_to_inc  = r_to_cnt + 1'b1;

    // Next-state, run bookkeeping and FIFO accept/drop decisions.
    always_comb begin
        w_state_d   = r_state;
        w_gap_cnt_d = r_gap_cnt;
        w_to_cnt_d  = r_to_cnt;
        w_num_d     = r_num;
        w_os_d      = r_os;
        w_cnt_d     = r_cnt;
        w_done_d    = 1'b0;
        w_ovf_d     = r_ovf;
        w_to_d      = r_to;
        w_push_req  = 1'b0;
        w_push      = 1'b0;
        w_occ_d     = r_occ;

        unique case (r_state)
            StIdle: begin
                // Stop wins over a simultaneous start.
                if (bus.start_in && !bus.stop_in) begin
                    w_state_d   = StGap;
                    w_gap_cnt_d = '0;
                    w_num_d     = bus.num_samples_in;
                    w_os_d      = bus.oversample_cfg_in;
                    w_cnt_d     = '0;
                    w_ovf_d     = 1'b0;
                    w_to_d      = 1'b0;
                end
            end
            StGap: begin
                if (bus.stop_in) begin
                    w_state_d = StIdle;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_state_d  = StRun;
                    w_to_cnt_d = '0;
                end else begin
                    w_gap_cnt_d = r_gap_cnt + 1'b1;
                end
            end
            StRun: begin
                if (bus.adc_valid_in) begin
                    w_push_req = 1'b1;
                    w_cnt_d    = w_cnt_inc;
                    w_to_cnt_d = '0;
                end else begin
                    w_to_cnt_d = w_to_inc;
                end
                // Final word beats stop, stop beats timeout.
                if (bus.adc_valid_in && (r_num != '0) && (w_cnt_inc == r_num)) begin
                    w_done_d  = 1'b1;
                    w_state_d = StIdle;
                end else if (bus.stop_in) begin
                    w_state_d = StIdle;
                end else if (!bus.adc_valid_in && (w_to_inc == TO_LIMIT)) begin
                    w_to_d    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // A full FIFO still accepts a push when the host pops in the same cycle.
        w_push = w_push_req & (~w_full | w_pop);
        if (w_push_req && w_full && !w_pop) begin
            w_ovf_d = 1'b1;
        end

        unique case ({w_push, w_pop})
            2'b10:   w_occ_d = r_occ + 1'b1;
            2'b01:   w_occ_d = r_occ - 1'b1;
            default: w_occ_d = r_occ;
        endcase
    end

    // Control state, status registers and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
            r_num     <= '0;
            r_cnt     <= '0;
            r_os      <= 10'h0ff;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_to      <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
        end else begin
            r_state   <= w_state_d;
            r_gap_cnt <= w_gap_cnt_d;
            r_to_cnt  <= w_to_cnt_d;
            r_num     <= w_num_d;
            r_cnt     <= w_cnt_d;
            r_os      <= w_os_d;
            r_en      <= (w_state_d == StRun);
            r_busy    <= (w_state_d != StIdle);
            r_done    <= w_done_d;
            r_ovf     <= w_ovf_d;
            r_to      <= w_to_d;
            r_occ     <= w_occ_d;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.adc_data_in;
        end
    end

    assign bus.adc_enable_out     = r_en;
    assign bus.adc_oversample_out = r_os;
    assign bus.rd_data_out        = w_empty ? '0 : r_mem[r_rptr];
    assign bus.rd_empty_out       = w_empty;
    assign bus.busy_out           = r_busy;
    assign bus.done_out           = r_done;
    assign bus.overflow_out       = r_ovf;
    assign bus.timeout_out        = r_to;
    assign bus.sample_cnt_out     = r_cnt;
endmodule
